// File: rtl/i2c_target_responder.sv
// I2C target with a small register file: SCL/SDA are oversampled on clk_i,
// SDA is driven open-drain, and a write-loaded pointer auto-increments.
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h22,
  parameter int         MEM_DEPTH   = 16,
  localparam int        PTR_W       = $clog2(MEM_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic             busy_o,
  output logic             addr_hit_o,
  output logic             wr_valid_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             rd_valid_o
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       shreg_q, shreg_d;
  logic [7:0]       tx_q, tx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             first_byte_q, first_byte_d;
  logic             sda_oe_d, busy_d, addr_hit_d, wr_valid_d, rd_valid_d;
  logic [PTR_W-1:0] wr_addr_d;
  logic [7:0]       wr_data_d;
  logic             mem_we;
  logic [7:0]       rx_byte;
  logic [7:0]       mem [MEM_DEPTH];

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Synchronizers reset to the idle bus level so reset never fakes a START/STOP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  assign rx_byte = {shreg_q, sda_s2};
  assign ptr_inc = ptr_q + PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      tx_q         <= '0;
      ptr_q        <= '0;
      first_byte_q <= 1'b0;
      sda_oe_o     <= 1'b0;
      busy_o       <= 1'b0;
      addr_hit_o   <= 1'b0;
      wr_valid_o   <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      rd_valid_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      tx_q         <= tx_d;
      ptr_q        <= ptr_d;
      first_byte_q <= first_byte_d;
      sda_oe_o     <= sda_oe_d;
      busy_o       <= busy_d;
      addr_hit_o   <= addr_hit_d;
      wr_valid_o   <= wr_valid_d;
      wr_addr_o    <= wr_addr_d;
      wr_data_o    <= wr_data_d;
      rd_valid_o   <= rd_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[ptr_q] <= rx_byte;
    end
  end

  // START/STOP override everything; otherwise bits are shifted on scl_rise and
  // SDA is only ever changed on scl_fall so it is stable while SCL is high.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    tx_d         = tx_q;
    ptr_d        = ptr_q;
    first_byte_d = first_byte_q;
    sda_oe_d     = sda_oe_o;
    busy_d       = busy_o;
    addr_hit_d   = 1'b0;
    wr_valid_d   = 1'b0;
    rd_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_o;
    wr_data_d    = wr_data_o;
    mem_we       = 1'b0;

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: sda_oe_d = 1'b0;

        ADDR: begin
          if (scl_rise) begin
            shreg_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = (rx_byte[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
            end
          end
        end

        // shreg_q[0] still holds the R/W bit of the address byte here.
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b1;
          end else if (scl_rise) begin
            addr_hit_d = 1'b1;
            bit_cnt_d  = '0;
            if (shreg_q[0]) begin
              tx_d    = mem[ptr_q];
              state_d = RD_BYTE;
            end else begin
              first_byte_d = 1'b1;
              state_d      = WR_BYTE;
            end
          end
        end

        WR_BYTE: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            shreg_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = WR_ACK;
              if (first_byte_q) begin
                ptr_d = rx_byte[PTR_W-1:0];
              end else begin
                mem_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
                ptr_d      = ptr_inc;
              end
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b1;
          end else if (scl_rise) begin
            first_byte_d = 1'b0;
            state_d      = WR_BYTE;
          end
        end

        // The first scl_fall seen here ends the ACK slot and presents the MSB.
        RD_BYTE: begin
          if (scl_fall) begin
            sda_oe_d = ~tx_q[3'd7 - bit_cnt_q];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RD_ACK;
          end
        end

        RD_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            rd_valid_d = 1'b1;
            ptr_d      = ptr_inc;
            if (sda_s2) begin
              state_d = IGNORE;
            end else begin
              tx_d    = mem[ptr_inc];
              state_d = RD_BYTE;
            end
          end
        end

        IGNORE: sda_oe_d = 1'b0;

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: an I2C master model drives SCL/SDA and a
// scoreboard checks write pulses, read data, ACKs and the pointer.
module tb_i2c_target_responder;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_oe, busy, addr_hit, wr_valid, rd_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda_line = m_sda & ~sda_oe;

  int pass_cnt = 0;
  int total_cnt = 0;
  int hit_cnt = 0;
  int rd_cnt = 0;

  logic [11:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  got_rd_q[$];

  always #5 clk = ~clk;

  i2c_target_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl),
    .sda_i      (sda_line),
    .sda_oe_o   (sda_oe),
    .busy_o     (busy),
    .addr_hit_o (addr_hit),
    .wr_valid_o (wr_valid),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .rd_valid_o (rd_valid)
  );

  // Write pulses are matched against the expectations queued by the tests.
  always @(negedge clk) begin
    if (addr_hit) hit_cnt++;
    if (rd_valid) rd_cnt++;
    if (wr_valid) begin
      total_cnt++;
      if (exp_wr_q.size() == 0) begin
        $display("[TB] FAIL wr_pulse unexpected: got %h/%h, want none", wr_addr, wr_data);
      end else begin
        logic [11:0] exp;
        exp = exp_wr_q.pop_front();
        if ({wr_addr, wr_data} !== exp)
          $display("[TB] FAIL wr_pulse: got %h/%h, want %h/%h", wr_addr, wr_data, exp[11:8], exp[7:0]);
        else
          pass_cnt++;
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      m_sda = 1'b1; wait_q();
      scl = 1'b1;   wait_q();
    end
    m_sda = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wait_q();
    scl = 1'b1; wait_q();
    wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    b = sda_line; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  // Sets the pointer, then reads n bytes (NACK on the last) into got_rd_q.
  task automatic read_frame(input logic [3:0] p, input int n, output logic all_ack);
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h44, a0);
    write_byte({4'h0, p}, a1);
    i2c_start();
    write_byte(8'h45, a2);
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1));
      got_rd_q.push_back(d);
    end
    i2c_stop();
    all_ack = ~(a0 | a1 | a2);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({sda_oe, busy, addr_hit, wr_valid, rd_valid} !== 5'b0)
      $display("[TB] FAIL reset_ctl: got %b, want 00000", {sda_oe, busy, addr_hit, wr_valid, rd_valid});
    else pass_cnt++;
    total_cnt++;
    if ({wr_addr, wr_data} !== 12'h000)
      $display("[TB] FAIL reset_wr_bus: got %h, want 000", {wr_addr, wr_data});
    else pass_cnt++;
    total_cnt++;
    if (dut.ptr_q !== 4'h0) $display("[TB] FAIL reset_ptr: got %h, want 0", dut.ptr_q);
    else pass_cnt++;
  endtask

  task automatic test_write();
    logic [7:0] bytes [4] = '{8'h44, 8'h03, 8'hA5, 8'h5A};
    logic ack;
    int hits0 = hit_cnt;
    exp_wr_q.push_back({4'h3, 8'hA5});
    exp_wr_q.push_back({4'h4, 8'h5A});
    i2c_start();
    foreach (bytes[i]) begin
      write_byte(bytes[i], ack);
      total_cnt++;
      if (ack !== 1'b0) $display("[TB] FAIL write_ack byte%0d: got %b, want 0", i, ack);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy !== 1'b1) $display("[TB] FAIL write_busy_in_frame: got %b, want 1", busy);
    else pass_cnt++;
    i2c_stop();
    wait_q();
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL write_busy_after_stop: got %b, want 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (exp_wr_q.size() != 0) $display("[TB] FAIL write_pulses_missing: got %0d left, want 0", exp_wr_q.size());
    else pass_cnt++;
    total_cnt++;
    if (hit_cnt - hits0 !== 1) $display("[TB] FAIL write_addr_hits: got %0d, want 1", hit_cnt - hits0);
    else pass_cnt++;
    total_cnt++;
    if (dut.ptr_q !== 4'h5) $display("[TB] FAIL write_ptr: got %h, want 5", dut.ptr_q);
    else pass_cnt++;
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d;
    int rd0 = rd_cnt;
    exp_rd_q.push_back(8'hA5);
    exp_rd_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'h44, a0);
    write_byte(8'h03, a1);
    i2c_start();
    write_byte(8'h45, a2);
    total_cnt++;
    if ({a0, a1, a2} !== 3'b000) $display("[TB] FAIL read_setup_acks: got %b, want 000", {a0, a1, a2});
    else pass_cnt++;
    read_byte(d, 1'b0);
    got_rd_q.push_back(d);
    read_byte(d, 1'b1);
    got_rd_q.push_back(d);
    total_cnt++;
    if (sda_oe !== 1'b0) $display("[TB] FAIL read_release_after_nack: got %b, want 0", sda_oe);
    else pass_cnt++;
    i2c_stop();
    while (exp_rd_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_rd_q.pop_front();
      g = got_rd_q.pop_front();
      total_cnt++;
      if (g !== e) $display("[TB] FAIL read_data: got %h, want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (rd_cnt - rd0 !== 2) $display("[TB] FAIL read_rd_valid: got %0d, want 2", rd_cnt - rd0);
    else pass_cnt++;
    total_cnt++;
    if (dut.ptr_q !== 4'h5) $display("[TB] FAIL read_ptr: got %h, want 5", dut.ptr_q);
    else pass_cnt++;
  endtask

  task automatic test_bad_addr();
    logic ack0, ack1;
    int hits0 = hit_cnt;
    i2c_start();
    write_byte(8'h46, ack0);
    write_byte(8'h12, ack1);
    total_cnt++;
    if ({ack0, ack1} !== 2'b11) $display("[TB] FAIL bad_addr_nack: got %b, want 11", {ack0, ack1});
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("[TB] FAIL bad_addr_busy: got %b, want 1", busy);
    else pass_cnt++;
    i2c_stop();
    wait_q();
    total_cnt++;
    if (hit_cnt - hits0 !== 0) $display("[TB] FAIL bad_addr_hits: got %0d, want 0", hit_cnt - hits0);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL bad_addr_busy_after_stop: got %b, want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [7:0] bytes [4] = '{8'h44, 8'h0F, 8'h11, 8'h22};
    logic ack, all_ack;
    logic nack_seen = 1'b0;
    exp_wr_q.push_back({4'hF, 8'h11});
    exp_wr_q.push_back({4'h0, 8'h22});
    i2c_start();
    foreach (bytes[i]) begin
      write_byte(bytes[i], ack);
      nack_seen |= ack;
    end
    i2c_stop();
    total_cnt++;
    if (nack_seen !== 1'b0) $display("[TB] FAIL wrap_acks: got nack, want all ack");
    else pass_cnt++;
    total_cnt++;
    if (dut.ptr_q !== 4'h1) $display("[TB] FAIL wrap_ptr: got %h, want 1", dut.ptr_q);
    else pass_cnt++;
    exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h22);
    read_frame(4'hF, 2, all_ack);
    total_cnt++;
    if (all_ack !== 1'b1) $display("[TB] FAIL wrap_read_acks: got %b, want 1", all_ack);
    else pass_cnt++;
    while (exp_rd_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_rd_q.pop_front();
      g = got_rd_q.pop_front();
      total_cnt++;
      if (g !== e) $display("[TB] FAIL wrap_read_data: got %h, want %h", g, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h44, a0);
    write_byte(8'h00, a1);
    i2c_start();
    write_byte(8'h45, a2);
    m_sda = 1'b1;
    wait_q();
    total_cnt++;
    if (sda_oe !== 1'b1) $display("[TB] FAIL rstmid_driving_msb: got %b, want 1", sda_oe);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({sda_oe, busy} !== 2'b00) $display("[TB] FAIL rstmid_release: got %b, want 00", {sda_oe, busy});
    else pass_cnt++;
    i2c_stop();
    i2c_start();
    write_byte(8'h45, a3);
    read_byte(d, 1'b1);
    i2c_stop();
    total_cnt++;
    if ({a0, a1, a2, a3} !== 4'b0000) $display("[TB] FAIL rstmid_acks: got %b, want 0000", {a0, a1, a2, a3});
    else pass_cnt++;
    total_cnt++;
    if (d !== 8'h00) $display("[TB] FAIL rstmid_fresh_read: got %h, want 00", d);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic ack, nack_seen, all_ack;
    logic [7:0] bytes [3] = '{8'h44, 8'h00, 8'h77};
    int hits0 = hit_cnt;
    nack_seen = 1'b0;
    i2c_start();
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    i2c_stop();
    wait_q();
    total_cnt++;
    if ({busy, sda_oe} !== 2'b00 || hit_cnt != hits0)
      $display("[TB] FAIL abort_idle: got busy/oe %b hits %0d, want 00 hits 0", {busy, sda_oe}, hit_cnt - hits0);
    else pass_cnt++;
    exp_wr_q.push_back({4'h0, 8'h77});
    i2c_start();
    foreach (bytes[i]) begin
      write_byte(bytes[i], ack);
      nack_seen |= ack;
    end
    i2c_stop();
    total_cnt++;
    if (nack_seen !== 1'b0) $display("[TB] FAIL abort_write_acks: got nack, want all ack");
    else pass_cnt++;
    exp_rd_q.push_back(8'h77);
    read_frame(4'h0, 1, all_ack);
    total_cnt++;
    if (all_ack !== 1'b1) $display("[TB] FAIL abort_read_acks: got %b, want 1", all_ack);
    else pass_cnt++;
    begin
      logic [7:0] e, g;
      e = exp_rd_q.pop_front();
      g = got_rd_q.pop_front();
      total_cnt++;
      if (g !== e) $display("[TB] FAIL abort_read_data: got %h, want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (exp_wr_q.size() != 0) $display("[TB] FAIL final_wr_pulses_missing: got %0d left, want 0", exp_wr_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_addr();
    test_wrap();
    test_reset_mid_read();
    test_abort();
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
